// File: rtl/execute_stage_if.sv
// Issue and write-back signal bundle between decode, the execute stage and the register file.
// The execute stage takes the slave side; decode (or a bench) takes the master side.
interface execute_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 4
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [OP_W-1:0]       opcode;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic [REG_ADDR_W-1:0] wr_port_C;
    logic [DATA_W-1:0]     wr_data_C;
    logic                  write_en_c;
    logic                  write_back;
    logic                  busy;

    modport master (
        output issue_valid, opcode, rd_addr, op_a, op_b,
        input  issue_ready, wr_port_C, wr_data_C, write_en_c, write_back, busy
    );

    modport slave (
        input  issue_valid, opcode, rd_addr, op_a, op_b,
        output issue_ready, wr_port_C, wr_data_C, write_en_c, write_back, busy
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiply,
// presenting a registered write-back triple to register-file write port C.
module execute_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 4
) (
    input logic            clk,
    input logic            reset,
    execute_stage_if.slave io
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(8);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(9);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     res;
    } wb_t;

    state_t                state, state_d;
    logic                  accept, mul_start, alu_issue;
    logic [DATA_W-1:0]     alu_res;
    logic [SH_W-1:0]       shamt;

    wb_t                   pipe_q;
    logic                  vld_q;

    logic [DATA_W-1:0]     mcand, mplier, acc;
    logic [CNT_W-1:0]      cnt;
    logic [REG_ADDR_W-1:0] mul_rd;

    logic [REG_ADDR_W-1:0] wr_port_q;
    logic [DATA_W-1:0]     wr_data_q;
    logic                  we_q;

    assign io.issue_ready = (state != MUL);
    assign io.busy        = (state == MUL);
    assign io.wr_port_C   = wr_port_q;
    assign io.wr_data_C   = wr_data_q;
    assign io.write_en_c  = we_q;
    assign io.write_back  = we_q;

    assign accept    = io.issue_valid && io.issue_ready;
    assign mul_start = accept && (io.opcode == OP_MUL);
    // Opcodes below MUL are the single-cycle ALU group; x0 targets never get a slot.
    assign alu_issue = accept && (io.opcode < OP_MUL) && (io.rd_addr != '0);
    assign shamt     = io.op_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (io.opcode)
            OP_ADD:  alu_res = io.op_a + io.op_b;
            OP_SUB:  alu_res = io.op_a - io.op_b;
            OP_AND:  alu_res = io.op_a & io.op_b;
            OP_OR:   alu_res = io.op_a | io.op_b;
            OP_XOR:  alu_res = io.op_a ^ io.op_b;
            OP_SLL:  alu_res = io.op_a << shamt;
            OP_SRL:  alu_res = io.op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(io.op_a) >>> shamt);
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(io.op_a) < $signed(io.op_b))};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (mul_start) state_d = MUL;
            MUL:     if (cnt == LAST_ITER) state_d = DONE;
            DONE:    state_d = mul_start ? MUL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift-add multiplier: one multiplier bit retired per cycle while in MUL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            mul_rd <= '0;
        end else if (mul_start) begin
            mcand  <= io.op_a;
            mplier <= io.op_b;
            acc    <= '0;
            cnt    <= '0;
            mul_rd <= io.rd_addr;
        end else if (state == MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= alu_issue;
            if (alu_issue) pipe_q <= '{rd: io.rd_addr, res: alu_res};
        end
    end

    // A multiply result and an ALU result never land on the same edge: nothing
    // is accepted during MUL, so the ALU slot is empty whenever DONE retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_port_q <= '0;
            wr_data_q <= '0;
            we_q      <= 1'b0;
        end else if (state == DONE && mul_rd != '0) begin
            wr_port_q <= mul_rd;
            wr_data_q <= acc;
            we_q      <= 1'b1;
        end else if (vld_q) begin
            wr_port_q <= pipe_q.rd;
            wr_data_q <= pipe_q.res;
            we_q      <= 1'b1;
        end else begin
            we_q      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed table, multiply/reset sequences and
// random traffic scored against an edge-indexed model of expected register writes.
module tb_execute_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    execute_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .OP_W(4)) io ();

    execute_stage #(.DATA_W(32), .REG_ADDR_W(5), .OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   edges = 0;
    int   mul_edge = -1000;
    wr_t  expq[$];
    logic [4:0]  last_port = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edges);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return $unsigned($signed(a) >>> sh);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // Stage is unavailable for the 32 cycles following a multiply's accepting edge.
    function automatic bit model_ready();
        return !(edges >= mul_edge && edges <= mul_edge + 31);
    endfunction

    task automatic check_outputs();
        if (expq.size() > 0 && expq[0].cyc < edges) begin
            n_cmp++; n_err++;
            $display("FAIL missed_write: expected write rd=%0d at edge %0d not seen", expq[0].rd, expq[0].cyc);
            void'(expq.pop_front());
        end
        if (expq.size() > 0 && expq[0].cyc == edges) begin
            chk("write_en", 32'(io.write_en_c), 32'd1);
            chk("wr_port", 32'(io.wr_port_C), 32'(expq[0].rd));
            chk("wr_data", io.wr_data_C, expq[0].d);
            last_port = expq[0].rd;
            last_data = expq[0].d;
            void'(expq.pop_front());
        end else begin
            chk("write_en_idle", 32'(io.write_en_c), 32'd0);
            chk("wr_port_hold", 32'(io.wr_port_C), 32'(last_port));
            chk("wr_data_hold", io.wr_data_C, last_data);
        end
        chk("write_back", 32'(io.write_back), 32'(io.write_en_c));
    endtask

    // One cycle: drive at the falling edge, score the following rising edge.
    task automatic cycle(input bit v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        bit rdy, acc;
        wr_t w;
        io.issue_valid = v;
        io.opcode      = op;
        io.op_a        = a;
        io.op_b        = b;
        io.rd_addr     = rd;
        rdy = model_ready();
        chk("issue_ready", 32'(io.issue_ready), 32'(rdy));
        chk("busy", 32'(io.busy), 32'(!rdy));
        acc = v && rdy;
        @(posedge clk);
        edges++;
        if (acc) begin
            if (op == 4'd9) mul_edge = edges;
            if (op <= 4'd9 && rd != 5'd0) begin
                w.cyc = (op == 4'd9) ? edges + 33 : edges + 1;
                w.rd  = rd;
                w.d   = exp;
                expq.push_back(w);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 4'd0, $urandom, $urandom, 5'($urandom), 32'd0);
    endtask

    task automatic chk_cleared();
        chk("rst_wr_port", 32'(io.wr_port_C), 32'd0);
        chk("rst_wr_data", io.wr_data_C, 32'd0);
        chk("rst_write_en", 32'(io.write_en_c), 32'd0);
        chk("rst_write_back", 32'(io.write_back), 32'd0);
        chk("rst_busy", 32'(io.busy), 32'd0);
    endtask

    task automatic model_reset();
        expq.delete();
        mul_edge  = -1000;
        last_port = '0;
        last_data = '0;
    endtask

    vec_t tbl[$];

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;

        tbl.push_back('{4'd0,  32'h00000040, 32'h00000060, 5'd3,  32'h000000A0});
        tbl.push_back('{4'd1,  32'h00000040, 32'h00000060, 5'd6,  32'hFFFFFFE0});
        tbl.push_back('{4'd7,  32'hEEEE3721, 32'h00000004, 5'd7,  32'hFEEEE372});
        tbl.push_back('{4'd6,  32'hEEEE3721, 32'h00000004, 5'd8,  32'h0EEEE372});
        tbl.push_back('{4'd8,  32'hFFFF765E, 32'h1FFF756F, 5'd10, 32'h00000001});
        tbl.push_back('{4'd8,  32'h1FFF756F, 32'hFFFF765E, 5'd11, 32'h00000000});
        tbl.push_back('{4'd0,  32'h12345678, 32'h11111111, 5'd0,  32'h23456789});
        tbl.push_back('{4'd12, 32'hDEADBEEF, 32'h00000001, 5'd5,  32'h00000000});
        tbl.push_back('{4'd2,  32'hF0F0AAAA, 32'h0FF05555, 5'd12, 32'h00F00000});
        tbl.push_back('{4'd3,  32'hF0F00000, 32'h0000000F, 5'd13, 32'hF0F0000F});
        tbl.push_back('{4'd4,  32'hFFFF0000, 32'hFF00FF00, 5'd14, 32'h00FFFF00});
        tbl.push_back('{4'd5,  32'h80000001, 32'hFFFFFFE1, 5'd15, 32'h00000002});
        tbl.push_back('{4'd7,  32'h7FFFFFFF, 32'h0000001F, 5'd16, 32'h00000000});
        tbl.push_back('{4'd0,  32'hFFFFFFFF, 32'h00000001, 5'd31, 32'h00000000});

        io.issue_valid = 1'b0;
        io.opcode = '0; io.op_a = '0; io.op_b = '0; io.rd_addr = '0;

        // Reset held with random inputs: outputs must stay cleared.
        for (int i = 0; i < 4; i++) begin
            io.issue_valid = 1'($urandom);
            io.opcode  = 4'($urandom);
            io.op_a    = $urandom;
            io.op_b    = $urandom;
            io.rd_addr = 5'($urandom);
            @(posedge clk); edges++;
            @(negedge clk);
            chk_cleared();
        end
        io.issue_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 32'(io.issue_ready), 32'd1);
        chk("post_rst_busy", 32'(io.busy), 32'd0);

        foreach (tbl[i]) cycle(1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);
        idle(2);

        // Multiply with an issue attempt in the busy window, then a DONE-cycle issue.
        cycle(1, 4'd9, 32'hFFFF856D, 32'h00000060, 5'd9, 32'hFFD208E0);
        for (int i = 0; i < 32; i++)
            cycle(i == 5 || i == 31, 4'd0, 32'h1, 32'h2, 5'd4, 32'h3);
        cycle(1, 4'd0, 32'h00000005, 32'h00000007, 5'd17, 32'h0000000C);
        idle(3);

        // Multiply to x0: computed but never written.
        cycle(1, 4'd9, 32'h00001234, 32'h00000010, 5'd0, 32'h00012340);
        idle(36);

        // Reset ten edges into a multiply aborts it with no write.
        cycle(1, 4'd9, 32'h00000003, 32'h00000005, 5'd20, 32'h0000000F);
        idle(10);
        reset = 1'b0;
        #1;
        chk_cleared();
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); edges++;
            @(negedge clk);
            chk_cleared();
        end
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(io.issue_ready), 32'd1);
        idle(40);

        // Random traffic; multiplies kept rarer so single-cycle ops dominate.
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom);
            if (op == 4'd9 && ($urandom % 4) != 0) op = 4'd0;
            a  = $urandom;
            b  = ($urandom % 2) ? $urandom : 32'($urandom % 40);
            rd = 5'($urandom);
            cycle(($urandom % 4) != 0, op, a, b, rd, ref_op(op, a, b));
        end
        idle(40);
        if (expq.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d expected writes outstanding, required 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Pipeline stage 3 of the 4-stage RISC core. Sits between decode (register-file operand read) and write-back.
- Accepts two 32-bit operands, an opcode and a destination register address.
- Computes single-cycle ALU results, plus an iterative shift-add multiply.
- Presents a registered write-back triple (address, data, enable) to the register file write port C.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register address width
OP_W, 4, opcode width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
issue_valid  input  1  decode presents a valid instruction
issue_ready  output  1  stage can accept an instruction this cycle
opcode  input  OP_W  operation select
rd_addr  input  REG_ADDR_W  destination register
op_a  input  DATA_W  operand A (register port A data)
op_b  input  DATA_W  operand B (register port B data)
wr_port_C  output  REG_ADDR_W  write-back destination
wr_data_C  output  DATA_W  write-back data (true result, uncomplemented)
write_en_c  output  1  write-back enable, one-cycle pulse
write_back  output  1  write-back phase strobe, equals write_en_c
busy  output  1  multiply in progress

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; the multiply counter clears.
  - wr_port_C=0, wr_data_C=0, write_en_c=0, write_back=0, busy=0.
  - issue_ready=1 once reset=1 again.
- Issue acceptance: an instruction is accepted on a rising edge where issue_valid=1 and issue_ready=1. issue_ready = (state != MUL).
- Opcodes:
  - 0 ADD: a+b. 1 SUB: a-b. Both mod 2^32, carry/overflow discarded.
  - 2 AND. 3 OR. 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is op_b[4:0]; SRA sign-fills.
  - 8 SLT: signed compare, result is 32'd1 or 32'd0.
  - 9 MUL: low DATA_W bits of a*b (same for signed and unsigned).
  - 10-15 NOP: accepted, never writes.
- Single-cycle ops, accepted at edge N:
  - At edge N+1, wr_data_C and wr_port_C are registered and write_en_c=1 for one cycle.
  - Back-to-back issue every cycle is allowed; one write per accepted op.
- FSM states: IDLE, MUL, DONE.
  - IDLE: MUL accepted -> latch a, b, rd_addr; clear accumulator; counter=0; go to MUL with busy=1.
  - MUL: each cycle, if multiplier bit0=1 then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. After DATA_W iterations go to DONE.
  - DONE: write_en_c=1, wr_data_C=acc, wr_port_C=latched rd_addr, busy=0. A new issue may be accepted in DONE (issue_ready=1); next state is MUL or IDLE accordingly.
  - MUL latency: accepted at edge N, write_en_c high in the cycle following edge N+DATA_W+1 (N+33 at default width).
- issue_valid during MUL: ignored, since issue_ready=0; decode must hold it.
- rd_addr=0: the result is computed but write_en_c stays 0 (register 0 is never written).
- write_en_c=0 cycles: wr_port_C and wr_data_C hold their last values; write_back=0.
- Reset asserted mid-MUL: the operation is aborted with no write; state returns to IDLE immediately.
- No back-pressure from write-back; the register file accepts every write_en_c pulse.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0; after release, issue_ready=1 and busy=0.
- ADD/SUB: ADD a=0x40, b=0x60, rd=3 at edge N -> edge N+1: write_en_c=1, wr_port_C=3, wr_data_C=0x000000A0. Next cycle SUB, same operands, rd=6 -> wr_data_C=0xFFFFFFE0, write_en_c pulses on consecutive cycles.
- Shift/compare:
  - SRA a=0xEEEE3721, b=4 -> 0xFEEEE372.
  - SRL, same operands -> 0x0EEEE372.
  - SLT a=0xFFFF765E, b=0x1FFF756F -> 0x00000001.
  - SLT with operands swapped -> 0x00000000.
- MUL: a=0xFFFF856D, b=0x60, rd=9 at edge N:
  - busy=1 and issue_ready=0 for 32 cycles; an issue_valid pulse in that window is not accepted.
  - write_en_c=1 after edge N+33 with wr_data_C=0xFFD208E0, wr_port_C=9.
- x0 and NOP: ADD with rd=0 -> write_en_c stays 0. opcode 12 -> no write.
- Mid-operation reset: MUL accepted at N, reset=0 at N+10 for 2 cycles -> outputs clear at once; after release, no write_en_c pulse occurs and issue_ready=1.
